run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
Responder side of the processor's req/done run handshake; lives inside top_level between the external requester and the fetch/PC logic. Accepts a run request, loads the PC with the program start address, enables the core until a halt instruction retires or a watchdog expires, then reports completion via done. Also reports the run's cycle count and whether it ended by timeout.

Parameters:
D, 12, program counter / instruction address width
CYC_W, 16, width of cycle counter
MAX_CYCLES, 4096, watchdog limit on RUN cycles (1..2^CYC_W-1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  1  run request from host; level, four-phase handshake
halt  input  1  core decoded a halt instruction this cycle (only meaningful while core_en=1)
start_addr  input  D  PC value loaded at start of each run; sampled in IDLE when req accepted
pc_load  output  1  one-cycle pulse: PC <= pc_start
pc_start  output  D  registered copy of start_addr
core_en  output  1  enables PC advance and register/memory writes
done  output  1  run complete, held until req seen low
cycle_count  output  CYC_W  RUN cycles of current/last run
timeout  output  1  last run ended by watchdog, not halt

Behaviour:
- Reset (sync, active-high): state=IDLE; pc_load=0, pc_start=0, core_en=0, done=0, cycle_count=0, timeout=0. Reset in any state, including mid-RUN, aborts the run the same cycle; no done issued.
- All outputs registered; all are functions of state/registers only (Moore).
- States: IDLE, LOAD, RUN, DONE.
- IDLE: if req=1 at edge -> LOAD; capture pc_start<=start_addr, cycle_count<=0, timeout<=0.
- LOAD: pc_load=1 for exactly this one cycle; core_en=0 -> RUN unconditionally.
- RUN: core_en=1; cycle_count increments every RUN cycle, including the halt cycle.
  - halt=1 -> DONE, timeout=0.
  - else if cycle_count == MAX_CYCLES-1 (count after this cycle reaches MAX_CYCLES) -> DONE, timeout=1.
  - halt and watchdog in same cycle: halt wins, timeout=0.
  - req dropping during RUN is ignored; the run completes normally.
- DONE: done=1, core_en=0; cycle_count and timeout frozen. req=0 at edge -> IDLE (done falls next cycle). If req already low on entry, done is high exactly one cycle.
- req held high after DONE->IDLE is impossible (exit requires req=0); a new run needs a fresh low->high. Minimum req low time: 1 cycle.
- Latency: req sampled high at edge k -> pc_load high in cycle k+1 -> first core_en cycle k+2. Halt seen at edge m -> done high from m+1.
- cycle_count never wraps; bounded by MAX_CYCLES.

Optional Feature:
RUN_CTRL_STEP_EN: adds input port step (1 bit). When defined, in RUN core_en = step (combinational gate after the state register) and cycle_count/halt/watchdog advance only on cycles with step=1; halt ignored when step=0. When undefined, the port is absent and RUN behaves as above (core_en=1 every cycle).

Decomposition:
- run_ctrl_pkg: state enum type (IDLE, LOAD, RUN, DONE), default CYC_W/MAX_CYCLES localparams.
- No sub-module; the counter and watchdog compare are inline. Single FSM plus datapath registers.

Test Plan:
- Reset then req=1 at cycle 2, start_addr=12'h010, halt at 5th RUN cycle -> pc_load one cycle with pc_start=0x010, core_en 5 cycles, done=1, cycle_count=5, timeout=0.
- Hold req high 20 cycles after done -> done stays 1, no pc_load; req=0 -> done=0 next cycle; req=1 again -> second run starts, cycle_count restarts from 0.
- MAX_CYCLES=8, halt never asserted -> core_en exactly 8 cycles, done=1, timeout=1, cycle_count=8.
- MAX_CYCLES=8, halt on 8th RUN cycle -> timeout=0, cycle_count=8.
- req dropped in 3rd RUN cycle, halt on 6th -> done high exactly one cycle, then IDLE.
- reset=1 in 4th RUN cycle -> next cycle all outputs 0, state IDLE, no done; with RUN_CTRL_STEP_EN, step pulsed every other cycle, halt on 3rd step -> cycle_count=3.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared FSM state type and default sizing for the run controller
package run_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam int DEF_D          = 12;
    localparam int DEF_CYC_W      = 16;
    localparam int DEF_MAX_CYCLES = 4096;
endpackage

// File: rtl/run_ctrl.sv
// run_ctrl: req/done run handshake responder; loads PC, enables core until halt or watchdog (optional RUN_CTRL_STEP_EN adds single-step gating)
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int D          = DEF_D,
    parameter int CYC_W      = DEF_CYC_W,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             halt,
`ifdef RUN_CTRL_STEP_EN
    input  logic             step,
`endif
    input  logic [D-1:0]     start_addr,
    output logic             pc_load,
    output logic [D-1:0]     pc_start,
    output logic             core_en,
    output logic             done,
    output logic [CYC_W-1:0] cycle_count,
    output logic             timeout
);
    state_t           r_state;
    state_t           w_next;
    logic [D-1:0]     r_pc_start;
    logic [CYC_W-1:0] r_cycle_count;
    logic             r_timeout;
    logic             w_adv;
    logic             w_halt;
    logic             w_wd;

`ifdef RUN_CTRL_STEP_EN
    assign w_adv = step;
`else
    assign w_adv = 1'b1;
`endif
    assign w_halt = w_adv && halt;
    assign w_wd   = w_adv && (r_cycle_count == CYC_W'(MAX_CYCLES - 1));

    assign pc_load     = (r_state == LOAD);
    assign core_en     = (r_state == RUN) && w_adv;
    assign done        = (r_state == DONE);
    assign pc_start    = r_pc_start;
    assign cycle_count = r_cycle_count;
    assign timeout     = r_timeout;

    // State register; reset aborts any run immediately
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state: halt takes priority over watchdog, both only on advancing RUN cycles
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = req ? LOAD : IDLE;
            LOAD:    w_next = RUN;
            RUN:     w_next = (w_halt || w_wd) ? DONE : RUN;
            DONE:    w_next = req ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture start address on accept, count advancing RUN cycles, flag watchdog ends
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_start    <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
        end else if (r_state == IDLE && req) begin
            r_pc_start    <= start_addr;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
        end else if (r_state == RUN && w_adv) begin
            r_cycle_count <= r_cycle_count + 1'b1;
            r_timeout     <= w_wd && !w_halt;
        end
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized run-level checks of run_ctrl against a per-run expectation model
module tb_run_ctrl;
    localparam int MAX_C = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        halt = 1'b0;
`ifdef RUN_CTRL_STEP_EN
    logic        step = 1'b0;
`endif
    logic [11:0] start_addr = '0;
    logic        pc_load;
    logic [11:0] pc_start;
    logic        core_en;
    logic        done;
    logic [15:0] cycle_count;
    logic        timeout;
    int          total = 0;
    int          bad = 0;

    run_ctrl #(.D(12), .CYC_W(16), .MAX_CYCLES(MAX_C)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .halt(halt),
`ifdef RUN_CTRL_STEP_EN
        .step(step),
`endif
        .start_addr(start_addr),
        .pc_load(pc_load),
        .pc_start(pc_start),
        .core_en(core_en),
        .done(done),
        .cycle_count(cycle_count),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_pc_load"}, pc_load, 0);
        chk({tag, "_pc_start"}, pc_start, 0);
        chk({tag, "_core_en"}, core_en, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_count"}, cycle_count, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    // One complete run: halt_at is the advancing RUN cycle that asserts halt (0 = never),
    // drop_at is the RUN cycle where req falls (0 = keep high), hold = extra DONE cycles with req high
    task automatic do_run(input logic [11:0] addr, input int halt_at, input int drop_at, input int hold);
        int   exp_n;
        logic exp_to;
        int   s;
        int   it;
        logic st;
        exp_to = !(halt_at >= 1 && halt_at <= MAX_C);
        exp_n  = exp_to ? MAX_C : halt_at;
        req = 1'b1;
        start_addr = addr;
        tick;
        chk("load_pulse", pc_load, 1);
        chk("load_pc_start", pc_start, addr);
        chk("load_core_en", core_en, 0);
        start_addr = 12'($urandom);
        halt = 1'($urandom);
        tick;
        s = 0;
        it = 0;
        while (!done && it < 4 * MAX_C + 8) begin
`ifdef RUN_CTRL_STEP_EN
            st = 1'($urandom);
            step = st;
`else
            st = 1'b1;
`endif
            halt = st ? (s + 1 == halt_at) : 1'($urandom);
            if (it + 1 == drop_at) req = 1'b0;
            #1;
            chk("run_core_en", core_en, st);
            chk("run_pc_load", pc_load, 0);
            if (st) s++;
            it++;
            tick;
        end
        halt = 1'b0;
        chk("run_len", s, exp_n);
        chk("done_set", done, 1);
        chk("done_count", cycle_count, exp_n);
        chk("done_timeout", timeout, exp_to);
        chk("done_core_en", core_en, 0);
        chk("done_pc_start", pc_start, addr);
        if (req) begin
            for (int h = 0; h < hold; h++) begin
                halt = 1'($urandom);
                tick;
                chk("hold_done", done, 1);
                chk("hold_pc_load", pc_load, 0);
                chk("hold_count", cycle_count, exp_n);
            end
        end
        req = 1'b0;
        halt = 1'b0;
        tick;
        chk("idle_done", done, 0);
        chk("idle_count", cycle_count, exp_n);
        chk("idle_timeout", timeout, exp_to);
        chk("idle_core_en", core_en, 0);
        chk("idle_pc_load", pc_load, 0);
    endtask

    initial begin
        tick;
        tick;
        all_zero("reset");
        reset = 1'b0;
        tick;
        all_zero("idle");
        do_run(12'h010, 5, 0, 20);
        do_run(12'h2a5, 3, 0, 0);
        do_run(12'h7ff, 0, 0, 2);
        do_run(12'h123, 8, 0, 1);
        do_run(12'h456, 6, 3, 0);
        do_run(12'hfff, 9, 0, 0);
        do_run(12'h001, 1, 1, 3);
        req = 1'b1;
        start_addr = 12'h0ab;
`ifdef RUN_CTRL_STEP_EN
        step = 1'b1;
`endif
        repeat (5) tick;
        chk("rst_run_core_en", core_en, 1);
        reset = 1'b1;
        req = 1'b0;
        tick;
        all_zero("mid_reset");
        reset = 1'b0;
        tick;
        chk("post_reset_done", done, 0);
        chk("post_reset_core_en", core_en, 0);
        for (int r = 0; r < 25; r++) begin
            do_run(12'($urandom), int'($urandom_range(0, MAX_C + 2)),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0,
                   int'($urandom_range(0, 3)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
